// File: rtl/rv_shift_iter_pkg.sv
// Shared types for the iterative shift unit: ALU shift opcodes and the shifter FSM states.
package rv_shift_iter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    ALU_SLL = 2'd0,
    ALU_SRL = 2'd1,
    ALU_SRA = 2'd2
  } shift_op_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } shift_iter_st_e;

endpackage

// File: rtl/rv_shift_iter.sv
// Multi-cycle SLL/SRL/SRA unit: one right-shift datapath, STEP bits per cycle,
// left shifts handled by reversing the operand on entry and the result on exit.
module rv_shift_iter
  import rv_shift_iter_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  shift_op_e         req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_res,
  output logic              busy
);

  localparam int unsigned   LG       = $clog2(STEP);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  function automatic logic [DATA_W-1:0] bitrev32(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

  shift_iter_st_e    state_r;
  logic [DATA_W-1:0] data_r;
  logic              fill_r;
  logic              is_sll_r;
  logic [AMT_W-1:0]  rem_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_res_r;

  logic [AMT_W-1:0]  step_amt_s;
  logic [AMT_W-1:0]  rem_next_s;
  logic [DATA_W-1:0] shifted_s;
  logic              accept_s;
  logic              req_sll_s;

  assign req_ready = (state_r == SH_IDLE) & ~flush;
  assign accept_s  = req_valid & req_ready;
  assign req_sll_s = (req_op == ALU_SLL);
  assign rsp_valid = rsp_valid_r;
  assign rsp_res   = rsp_res_r;
  assign busy      = (state_r != SH_IDLE);

  // Step size for this cycle and the log-structured right shifter with fill
  always_comb begin
    step_amt_s = STEP_AMT;
    if (rem_r < STEP_AMT) begin
      step_amt_s = rem_r;
    end else begin
      step_amt_s = STEP_AMT;
    end
    rem_next_s = rem_r - step_amt_s;
    shifted_s  = data_r;
    // Only LG+1 constant-distance stages: step never exceeds STEP.
    for (int k = 0; k <= int'(LG); k++) begin
      if (step_amt_s[k]) begin
        shifted_s = fill_r ? ~((~shifted_s) >> (1 << k)) : (shifted_s >> (1 << k));
      end else begin
        shifted_s = shifted_s;
      end
    end
  end

  // Control FSM, datapath registers and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SH_IDLE;
      data_r      <= {DATA_W{1'b0}};
      fill_r      <= 1'b0;
      is_sll_r    <= 1'b0;
      rem_r       <= {AMT_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_res_r   <= {DATA_W{1'b0}};
    end else if (flush) begin
      state_r     <= SH_IDLE;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        SH_IDLE: begin
          if (accept_s) begin
            data_r   <= req_sll_s ? bitrev32(req_a) : req_a;
            fill_r   <= (req_op == ALU_SRA) & req_a[DATA_W-1];
            is_sll_r <= req_sll_s;
            rem_r    <= req_amt;
            state_r  <= (req_amt == {AMT_W{1'b0}}) ? SH_DONE : SH_SHIFT;
          end
        end
        SH_SHIFT: begin
          data_r <= shifted_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == {AMT_W{1'b0}}) begin
            state_r <= SH_DONE;
          end
        end
        SH_DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the consumer.
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_res_r   <= is_sll_r ? bitrev32(data_r) : data_r;
          end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= SH_IDLE;
          end
        end
        default: begin
          state_r     <= SH_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
